// File: rtl/edge_bbox_pkg.sv
// edge_bbox_pkg: FSM state encoding and width helper shared by the edge bounding-box blocks
package edge_bbox_pkg;

    typedef enum logic [1:0] {IDLE, ACTIVE, REPORT} state_t;

    // Bit width needed to index n values; never narrower than 1 bit.
    function automatic int width_of(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/edge_bbox_pos_cnt.sv
// edge_bbox_pos_cnt: pixel position counters, sync edge strobes and pixel-accept qualifier
//
// Ports:
//   clk, reset_n          pixel clock, asynchronous active-low reset
//   sobel_valid/hsync/vsync  incoming stream qualifiers
//   active                downstream FSM is collecting a frame
//   frame_start           clears the position counters at frame entry
//   accept                pixel counts towards the current line/frame
//   vsync_rise            registered vsync went 0 -> 1
//   vsync_low             registered vsync is 0
//   x, y                  column/line of the pixel currently presented
module edge_bbox_pos_cnt
    import edge_bbox_pkg::*;
#(
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480,
    localparam int XW = width_of(IMG_WIDTH),
    localparam int YW = width_of(IMG_HEIGHT)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          sobel_valid,
    input  logic          sobel_hsync,
    input  logic          sobel_vsync,
    input  logic          active,
    input  logic          frame_start,
    output logic          accept,
    output logic          vsync_rise,
    output logic          vsync_low,
    output logic [XW-1:0] x,
    output logic [YW-1:0] y
);

    localparam logic [XW-1:0] XMAX = XW'(IMG_WIDTH - 1);
    localparam logic [YW-1:0] YMAX = YW'(IMG_HEIGHT - 1);

    logic hs_q;
    logic vs_q;
    logic vs_qq;
    logic line_hit;
    logic hsync_fall;

    assign hsync_fall = hs_q && !sobel_hsync;
    assign accept     = active && sobel_valid && sobel_hsync && sobel_vsync;
    assign vsync_rise = vs_q && !vs_qq;
    assign vsync_low  = !vs_q;

    // vsync history resets high so a frame already in progress at reset
    // release is not mistaken for a rising edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hs_q     <= 1'b0;
            vs_q     <= 1'b1;
            vs_qq    <= 1'b1;
            line_hit <= 1'b0;
            x        <= '0;
            y        <= '0;
        end else begin
            hs_q  <= sobel_hsync;
            vs_q  <= sobel_vsync;
            vs_qq <= vs_q;
            if (frame_start) begin
                line_hit <= 1'b0;
                x        <= '0;
                y        <= '0;
            end else if (hsync_fall) begin
                line_hit <= 1'b0;
                x        <= '0;
                if (line_hit && y != YMAX)
                    y <= y + 1'b1;
            end else if (accept) begin
                line_hit <= 1'b1;
                if (x != XMAX)
                    x <= x + 1'b1;
            end
        end
    end

endmodule

// File: rtl/edge_bbox.sv
// edge_bbox: per-frame bounding box of edge pixels (sobel==0) in a binary edge stream
//
// Ports:
//   clk, reset_n             pixel clock, asynchronous active-low reset
//   sobel, sobel_valid       binary pixel (0 = edge) and its qualifier
//   sobel_hsync, sobel_vsync active line / active frame
//   bbox_x_min/x_max         box columns of the last reported frame
//   bbox_y_min/y_max         box lines of the last reported frame
//   bbox_found               last reported frame had a valid box
//   bbox_done                one-cycle pulse when the outputs above update
//   edge_count               edge pixels in the last reported frame (EDGE_BBOX_COUNT_EN only)
//
// Build option EDGE_BBOX_COUNT_EN: adds a saturating edge counter and the
// edge_count port; a box is then valid only with >= MIN_EDGE_PIXELS edges.
// Without it a single edge pixel makes the box valid.
module edge_bbox
    import edge_bbox_pkg::*;
#(
    parameter int IMG_WIDTH       = 640,
    parameter int IMG_HEIGHT      = 480,
    parameter int MIN_EDGE_PIXELS = 16,
    localparam int XW = width_of(IMG_WIDTH),
    localparam int YW = width_of(IMG_HEIGHT),
    localparam int CW = width_of(IMG_WIDTH * IMG_HEIGHT + 1)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          sobel,
    input  logic          sobel_valid,
    input  logic          sobel_hsync,
    input  logic          sobel_vsync,
    output logic [XW-1:0] bbox_x_min,
    output logic [XW-1:0] bbox_x_max,
    output logic [YW-1:0] bbox_y_min,
    output logic [YW-1:0] bbox_y_max,
    output logic          bbox_found,
    output logic          bbox_done
`ifdef EDGE_BBOX_COUNT_EN
    ,
    output logic [CW-1:0] edge_count
`endif
);

    localparam logic [XW-1:0] XMAX = XW'(IMG_WIDTH - 1);
    localparam logic [YW-1:0] YMAX = YW'(IMG_HEIGHT - 1);

    state_t        state;
    state_t        state_nx;
    logic          accept;
    logic          vsync_rise;
    logic          vsync_low;
    logic          frame_start;
    logic          report;
    logic          edge_px;
    logic          box_ok;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic [XW-1:0] x_min;
    logic [XW-1:0] x_max;
    logic [YW-1:0] y_min;
    logic [YW-1:0] y_max;

    edge_bbox_pos_cnt #(
        .IMG_WIDTH  (IMG_WIDTH),
        .IMG_HEIGHT (IMG_HEIGHT)
    ) u_pos (
        .clk         (clk),
        .reset_n     (reset_n),
        .sobel_valid (sobel_valid),
        .sobel_hsync (sobel_hsync),
        .sobel_vsync (sobel_vsync),
        .active      (state == ACTIVE),
        .frame_start (frame_start),
        .accept      (accept),
        .vsync_rise  (vsync_rise),
        .vsync_low   (vsync_low),
        .x           (x),
        .y           (y)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx    = state;
        frame_start = 1'b0;
        report      = 1'b0;
        case (state)
            IDLE: begin
                frame_start = vsync_rise;
                state_nx    = vsync_rise ? ACTIVE : IDLE;
            end
            ACTIVE:  state_nx = vsync_low ? REPORT : ACTIVE;
            REPORT: begin
                report   = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    assign edge_px = accept && !sobel;

`ifdef EDGE_BBOX_COUNT_EN
    logic [CW-1:0] edge_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            edge_cnt <= '0;
        else if (frame_start)
            edge_cnt <= '0;
        else if (edge_px && edge_cnt != '1)
            edge_cnt <= edge_cnt + 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            edge_count <= '0;
        else if (report)
            edge_count <= edge_cnt;
    end

    assign box_ok = edge_cnt >= CW'(MIN_EDGE_PIXELS);
`else
    logic any_edge;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            any_edge <= 1'b0;
        else if (frame_start)
            any_edge <= 1'b0;
        else if (edge_px)
            any_edge <= 1'b1;
    end

    assign box_ok = any_edge;
`endif

    // Accumulators start inverted (min at the far corner, max at 0) so the
    // first edge pixel of the frame sets both bounds.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            x_min <= '0;
            x_max <= '0;
            y_min <= '0;
            y_max <= '0;
        end else if (frame_start) begin
            x_min <= XMAX;
            x_max <= '0;
            y_min <= YMAX;
            y_max <= '0;
        end else if (edge_px) begin
            if (x < x_min) x_min <= x;
            if (x > x_max) x_max <= x;
            if (y < y_min) y_min <= y;
            if (y > y_max) y_max <= y;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bbox_x_min <= '0;
            bbox_x_max <= '0;
            bbox_y_min <= '0;
            bbox_y_max <= '0;
            bbox_found <= 1'b0;
            bbox_done  <= 1'b0;
        end else begin
            bbox_done <= report;
            if (report) begin
                bbox_x_min <= box_ok ? x_min : '0;
                bbox_x_max <= box_ok ? x_max : '0;
                bbox_y_min <= box_ok ? y_min : '0;
                bbox_y_max <= box_ok ? y_max : '0;
                bbox_found <= box_ok;
            end
        end
    end

endmodule

// File: tb/tb_edge_bbox.sv
// tb_edge_bbox: randomized and directed frames scored against a position-based reference model
module tb_edge_bbox;

    localparam int W    = 8;
    localparam int H    = 6;
    localparam int MINE = 2;
    localparam int XW   = 3;
    localparam int YW   = 3;
    localparam int CW   = 6;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          sobel = 1'b1;
    logic          sobel_valid = 1'b0;
    logic          sobel_hsync = 1'b0;
    logic          sobel_vsync = 1'b0;
    logic [XW-1:0] bbox_x_min;
    logic [XW-1:0] bbox_x_max;
    logic [YW-1:0] bbox_y_min;
    logic [YW-1:0] bbox_y_max;
    logic          bbox_found;
    logic          bbox_done;
`ifdef EDGE_BBOX_COUNT_EN
    logic [CW-1:0] edge_count;
`endif

    edge_bbox #(
        .IMG_WIDTH       (W),
        .IMG_HEIGHT      (H),
        .MIN_EDGE_PIXELS (MINE)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .sobel       (sobel),
        .sobel_valid (sobel_valid),
        .sobel_hsync (sobel_hsync),
        .sobel_vsync (sobel_vsync),
        .bbox_x_min  (bbox_x_min),
        .bbox_x_max  (bbox_x_max),
        .bbox_y_min  (bbox_y_min),
        .bbox_y_max  (bbox_y_max),
        .bbox_found  (bbox_found),
        .bbox_done   (bbox_done)
`ifdef EDGE_BBOX_COUNT_EN
        ,
        .edge_count  (edge_count)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int found;
        int xmin;
        int xmax;
        int ymin;
        int ymax;
        int cnt;
        int due;
    } exp_t;

    exp_t sb[$];
    int   npass = 0;
    int   ntot  = 0;

    int   nlines;
    int   nlen[16];
    bit   pv[16][32];
    bit   ps[16][32];

    task automatic chk(input string nm, input int act, input int exp);
        ntot++;
        if (act == exp)
            npass++;
        else
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_found"}, int'(bbox_found), 0);
        chk({tag, "_done"}, int'(bbox_done), 0);
        chk({tag, "_coords"}, int'({bbox_x_min, bbox_x_max, bbox_y_min, bbox_y_max}), 0);
`ifdef EDGE_BBOX_COUNT_EN
        chk({tag, "_count"}, int'(edge_count), 0);
`endif
    endtask

    task automatic clear_frame(input int nl);
        nlines = nl;
        for (int l = 0; l < 16; l++) begin
            nlen[l] = 0;
            for (int i = 0; i < 32; i++) begin
                pv[l][i] = 1'b0;
                ps[l][i] = 1'b1;
            end
        end
    endtask

    task automatic full_line(input int l);
        nlen[l] = W;
        for (int i = 0; i < W; i++) pv[l][i] = 1'b1;
    endtask

    // Drives the frame in pv/ps and pushes the expected report. The model
    // places a pixel by its ordinal among accepted pixels in the line and by
    // how many non-empty lines preceded it, both clipped to the image.
    task automatic send_frame(input bit simul);
        int   cnt = 0;
        int   xmn = W - 1;
        int   xmx = 0;
        int   ymn = H - 1;
        int   ymx = 0;
        int   yl  = 0;
        int   ok;
        exp_t e;
        sobel_vsync = 1'b1;
        repeat (4) @(negedge clk);
        for (int l = 0; l < nlines; l++) begin
            int k = 0;
            sobel_hsync = 1'b1;
            for (int i = 0; i < nlen[l]; i++) begin
                sobel_valid = pv[l][i];
                sobel       = ps[l][i];
                if (pv[l][i]) begin
                    if (!ps[l][i]) begin
                        int xc = (k < W - 1) ? k : W - 1;
                        int yc = (yl < H - 1) ? yl : H - 1;
                        cnt++;
                        if (xc < xmn) xmn = xc;
                        if (xc > xmx) xmx = xc;
                        if (yc < ymn) ymn = yc;
                        if (yc > ymx) ymx = yc;
                    end
                    k++;
                end
                @(negedge clk);
            end
            sobel_valid = 1'b0;
            sobel       = 1'b1;
            if (!(simul && l == nlines - 1)) begin
                sobel_hsync = 1'b0;
                if (k > 0) yl++;
                repeat (3) begin
                    sobel_valid = 1'($urandom_range(1, 0));
                    sobel       = 1'b0;
                    @(negedge clk);
                end
                sobel_valid = 1'b0;
                sobel       = 1'b1;
            end
        end
        if (!simul) repeat (2) @(negedge clk);
        sobel_hsync = 1'b0;
        sobel_vsync = 1'b0;
`ifdef EDGE_BBOX_COUNT_EN
        ok = (cnt >= MINE) ? 1 : 0;
`else
        ok = (cnt >= 1) ? 1 : 0;
`endif
        e.found = ok;
        e.xmin  = ok ? xmn : 0;
        e.xmax  = ok ? xmx : 0;
        e.ymin  = ok ? ymn : 0;
        e.ymax  = ok ? ymx : 0;
        e.cnt   = cnt;
        e.due   = cyc + 3;
        sb.push_back(e);
        repeat (5) @(negedge clk);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset_n && bbox_done) begin
                if (sb.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("done_latency", cyc, e.due);
                    chk("found", int'(bbox_found), e.found);
                    chk("x_min", int'(bbox_x_min), e.xmin);
                    chk("x_max", int'(bbox_x_max), e.xmax);
                    chk("y_min", int'(bbox_y_min), e.ymin);
                    chk("y_max", int'(bbox_y_max), e.ymax);
`ifdef EDGE_BBOX_COUNT_EN
                    chk("edge_count", int'(edge_count), e.cnt);
`endif
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stim
        repeat (3) @(negedge clk);
        chk_zero("reset");
        reset_n = 1'b1;
        repeat (3) @(negedge clk);

        // Edges at (2,1),(5,1),(3,4).
        clear_frame(H);
        for (int l = 0; l < H; l++) full_line(l);
        ps[1][2] = 1'b0;
        ps[1][5] = 1'b0;
        ps[4][3] = 1'b0;
        send_frame(1'b0);

        // Reset mid-frame, released while vsync stays high: nothing reported.
        sobel_vsync = 1'b1;
        repeat (4) @(negedge clk);
        sobel_hsync = 1'b1;
        sobel_valid = 1'b1;
        sobel       = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk_zero("async_reset");
        @(negedge clk);
        reset_n = 1'b1;
        repeat (5) @(negedge clk);
        sobel_valid = 1'b0;
        sobel       = 1'b1;
        sobel_hsync = 1'b0;
        repeat (2) @(negedge clk);
        sobel_vsync = 1'b0;
        repeat (8) @(negedge clk);
        chk_zero("after_discard");

        // Edges at (0,0),(1,0).
        clear_frame(H);
        for (int l = 0; l < H; l++) full_line(l);
        ps[0][0] = 1'b0;
        ps[0][1] = 1'b0;
        send_frame(1'b0);

        // All-white frame.
        clear_frame(H);
        for (int l = 0; l < H; l++) full_line(l);
        send_frame(1'b0);

        // Single edge in the far corner.
        clear_frame(H);
        for (int l = 0; l < H; l++) full_line(l);
        ps[5][7] = 1'b0;
        send_frame(1'b0);

        // Last pixel of last line is an edge; hsync and vsync fall together.
        clear_frame(H);
        for (int l = 0; l < H; l++) full_line(l);
        ps[5][7] = 1'b0;
        ps[2][4] = 1'b0;
        send_frame(1'b1);

        // Overlong lines and surplus lines exercise x/y saturation.
        clear_frame(8);
        for (int l = 0; l < 8; l++) begin
            nlen[l] = 11;
            for (int i = 0; i < 11; i++) pv[l][i] = 1'b1;
        end
        ps[0][10] = 1'b0;
        ps[7][1]  = 1'b0;
        send_frame(1'b0);

        for (int f = 0; f < 10; f++) begin
            clear_frame($urandom_range(8, 1));
            for (int l = 0; l < nlines; l++) begin
                nlen[l] = $urandom_range(11, 0);
                for (int i = 0; i < nlen[l]; i++) begin
                    pv[l][i] = ($urandom_range(3, 0) != 0);
                    ps[l][i] = ($urandom_range(7, 0) != 0);
                end
            end
            send_frame(1'($urandom_range(1, 0)));
        end

        repeat (10) @(negedge clk);
        chk("pending_reports", sb.size(), 0);
        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
